// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on request and result.
// Operation encoding matches the single-cycle shifter (L_R selects direction, A_L selects arithmetic right).
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             L_R,
    input  logic             A_L,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic             accept;

    // Single-bit step; arithmetic right replicates the sign bit via a signed shift.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] val,
        input logic             left,
        input logic             arith
    );
        logic signed [WIDTH-1:0] sval;
        sval = $signed(val);
        if (left) begin
            return {val[WIDTH-2:0], 1'b0};
        end else if (arith) begin
            return $unsigned(sval >>> 1);
        end else begin
            return {1'b0, val[WIDTH-1:1]};
        end
    endfunction

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign dout      = (state_q == DONE) ? data_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = din;
                    cnt_d   = shamt;
                    left_d  = L_R;
                    arith_d = A_L & ~L_R;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = shift_one(data_q, left_q, arith_q);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: directed and random shifts against an arithmetic reference,
// plus backpressure, input isolation and asynchronous reset scenarios.
module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             L_R;
    logic             A_L;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;

    int checks   = 0;
    int failures = 0;

    iter_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .L_R       (L_R),
        .A_L       (A_L),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int sh,
                                                   input bit lr, input bit al);
        logic signed [WIDTH-1:0] sd;
        sd = $signed(d);
        if (lr)      return d << sh;
        else if (al) return $unsigned(sd >>> sh);
        else         return d >> sh;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge with the unit idle; returns at #1 after the result handshake edge.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input int sh,
                          input bit lr, input bit al, input int bp);
        logic [WIDTH-1:0] exp;
        int n;
        exp = ref_shift(d, sh, lr, al);
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        din = d; shamt = SHW'(sh); L_R = lr; A_L = al; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        din = $urandom; shamt = SHW'($urandom); L_R = 1'($urandom); A_L = 1'($urandom);
        n = 1;
        while (!out_valid && n < WIDTH + 4) begin
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(sh + 1));
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " dout"}, dout, exp);
        check({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            din = $urandom;
            @(posedge clk); #1;
            check({tag, " bp_dout"}, dout, exp);
            check({tag, " bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, " bp_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post_dout"}, dout, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = '0; shamt = '0; L_R = 1'b0; A_L = 1'b0; out_ready = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset dout", dout, 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        din = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0; in_valid = 1'b0;
        #1 check("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("no accept during reset", 32'(in_ready), 32'd1);

        run_op("left4",      32'h0000_00F1, 4,  1'b1, 1'b0, 0);
        run_op("asr4",       32'h8000_0010, 4,  1'b0, 1'b1, 0);
        run_op("lsr4",       32'h8000_0010, 4,  1'b0, 1'b0, 0);
        run_op("zero_asr",   32'hDEAD_BEEF, 0,  1'b0, 1'b1, 0);
        run_op("zero_left",  32'hDEAD_BEEF, 0,  1'b1, 1'b1, 1);
        run_op("max_asr",    32'h8000_0000, 31, 1'b0, 1'b1, 0);
        run_op("max_lsr",    32'h8000_0000, 31, 1'b0, 1'b0, 0);
        run_op("max_left",   32'h0000_0003, 31, 1'b1, 1'b0, 0);
        run_op("left_al1",   32'h8765_4321, 5,  1'b1, 1'b1, 0);
        run_op("backpress",  32'h1234_5678, 9,  1'b1, 1'b0, 10);
        run_op("after_bp",   32'hC000_0F00, 3,  1'b0, 1'b1, 0);

        for (int k = 0; k < 25; k++) begin
            run_op("random", $urandom, int'($urandom_range(WIDTH - 1, 0)),
                   1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
        end

        // Asynchronous reset while shifting, with three steps still pending.
        din = 32'hA5A5_0001; shamt = SHW'(7); L_R = 1'b1; A_L = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1; in_valid = 1'b1;
        #1;
        check("midshift out_valid", 32'(out_valid), 32'd0);
        check("midshift dout", dout, 32'd0);
        check("midshift in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0; in_valid = 1'b0;
        #1 check("midshift release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        run_op("fresh_after_rst", 32'h0000_0001, 1, 1'b1, 1'b0, 0);

        // Asynchronous reset while the result is waiting for out_ready.
        din = 32'hFFFF_0000; shamt = SHW'(2); L_R = 1'b0; A_L = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_hold valid", 32'(out_valid), 32'd1);
        check("done_hold dout", dout, 32'hFFFF_C000);
        #2 rst = 1'b1;
        #1;
        check("done_rst out_valid", 32'(out_valid), 32'd0);
        check("done_rst dout", dout, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        run_op("final", 32'h7FFF_FFFF, 30, 1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
